// File: rtl/vga_sync_if.sv
// Raster timing bundle between vga_sync_gen (master) and its consumers (slave).
// The consumer side supplies the pixel tick enable; everything else flows out of the generator.
interface vga_sync_if;
  logic       pix_en;
  logic [9:0] xcounter;
  logic [9:0] ycounter;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       line_end;
  logic [9:0] max_x;
  logic [9:0] max_y;

  modport master (
    input  pix_en,
    output xcounter, ycounter, hsync, vsync, video_on,
           frame_start, line_end, max_x, max_y
  );

  modport slave (
    output pix_en,
    input  xcounter, ycounter, hsync, vsync, video_on,
           frame_start, line_end, max_x, max_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, phase FSMs, registered sync/video
// outputs that always describe the presented counter position, and per-tick strobes.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
      $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds 1024");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_chk
      $error("vga_sync_gen: timing parameters must be non-zero");
    end
  endgenerate

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ACT   = (SYNC_POL != 0);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_phase_e;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_phase_e;

  logic [9:0] x_p0, y_p0;
  logic [9:0] x_nxt, y_nxt;
  h_phase_e   h_state, h_nxt;
  v_phase_e   v_state, v_nxt;
  logic       hsync_p0, vsync_p0, video_p0;

  // Next raster position; holds when no pixel tick is present.
  always_comb begin
    x_nxt = x_p0;
    y_nxt = y_p0;
    if (vif.pix_en) begin
      if (x_p0 == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_p0 == V_LAST) ? '0 : y_p0 + 10'd1;
      end else begin
        x_nxt = x_p0 + 10'd1;
      end
    end
  end

  // Phases advance on the position being entered, so the registered syncs match it.
  always_comb begin
    h_nxt = h_state;
    case (h_state)
      H_ACT:   if (x_nxt == H_FP_START) h_nxt = H_FRONT;
      H_FRONT: if (x_nxt == H_SY_START) h_nxt = H_SYNCP;
      H_SYNCP: if (x_nxt == H_BP_START) h_nxt = H_BACK;
      H_BACK:  if (x_nxt == '0)         h_nxt = H_ACT;
      default: h_nxt = H_ACT;
    endcase
  end

  // y only moves at a line wrap, so vertical phases change only with xcounter -> 0.
  always_comb begin
    v_nxt = v_state;
    case (v_state)
      V_ACT:   if (y_nxt == V_FP_START) v_nxt = V_FRONT;
      V_FRONT: if (y_nxt == V_SY_START) v_nxt = V_SYNCP;
      V_SYNCP: if (y_nxt == V_BP_START) v_nxt = V_BACK;
      V_BACK:  if (y_nxt == '0)         v_nxt = V_ACT;
      default: v_nxt = V_ACT;
    endcase
  end

  // Stage p0: counter, phase and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_p0     <= '0;
      y_p0     <= '0;
      h_state  <= H_ACT;
      v_state  <= V_ACT;
      hsync_p0 <= ~SYNC_ACT;
      vsync_p0 <= ~SYNC_ACT;
      video_p0 <= 1'b1;
    end else begin
      x_p0     <= x_nxt;
      y_p0     <= y_nxt;
      h_state  <= h_nxt;
      v_state  <= v_nxt;
      hsync_p0 <= (h_nxt == H_SYNCP) ? SYNC_ACT : ~SYNC_ACT;
      vsync_p0 <= (v_nxt == V_SYNCP) ? SYNC_ACT : ~SYNC_ACT;
      video_p0 <= (h_nxt == H_ACT) && (v_nxt == V_ACT);
    end
  end

  assign vif.xcounter    = x_p0;
  assign vif.ycounter    = y_p0;
  assign vif.hsync       = hsync_p0;
  assign vif.vsync       = vsync_p0;
  assign vif.video_on    = video_p0;
  assign vif.frame_start = vif.pix_en & ~reset & (x_p0 == '0) & (y_p0 == '0);
  assign vif.line_end    = vif.pix_en & ~reset & (x_p0 == H_LAST);
  assign vif.max_x       = 10'(H_ACTIVE);
  assign vif.max_y       = 10'(V_ACTIVE);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing and a tiny 8x6 active-high configuration,
// each driven by a stimulus process feeding a scoreboard queue and an independent monitor.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  vga_sync_if if_a ();
  vga_sync_if if_b ();

  vga_sync_gen u_a (
    .clk   (clk),
    .reset (rst_a),
    .vif   (if_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1)
  ) u_b (
    .clk   (clk),
    .reset (rst_b),
    .vif   (if_b)
  );

  typedef struct {
    bit known;
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit fs;
    bit le;
    int mx;
    int my;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   p_a = 0, p_b = 0;
  bit   known_a = 0, known_b = 0;
  int   n_chk = 0, n_fail = 0;
  int   fs_cnt_b = 0;

  // Reference: the raster is a single pixel index p within the frame; x/y and every
  // output are plain arithmetic on that index and the configured timing numbers.
  function automatic exp_t predict(input int cfg, input int p, input bit r, input bit pe);
    exp_t e;
    int ha, hf, hs, hb, va, vf, vs, vb, ht;
    bit pol;
    if (cfg == 0) begin
      ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; pol = 1'b0;
    end else begin
      ha = 4; hf = 1; hs = 2; hb = 1; va = 3; vf = 1; vs = 1; vb = 1; pol = 1'b1;
    end
    ht    = ha + hf + hs + hb;
    e.x   = p % ht;
    e.y   = p / ht;
    e.hs  = (e.x >= ha + hf && e.x < ha + hf + hs) ? pol : !pol;
    e.vs  = (e.y >= va + vf && e.y < va + vf + vs) ? pol : !pol;
    e.von = (e.x < ha) && (e.y < va);
    e.fs  = pe && !r && (p == 0);
    e.le  = pe && !r && (e.x == ht - 1);
    e.mx  = ha;
    e.my  = va;
    e.known = 1'b0;
    return e;
  endfunction

  localparam int FT_A = 800 * 525;
  localparam int FT_B = 8 * 6;

  task automatic step_a(input bit r, input bit pe);
    exp_t e;
    @(posedge clk);
    #1;
    rst_a       = r;
    if_a.pix_en = pe;
    e = predict(0, p_a, r, pe);
    e.known = known_a;
    q_a.push_back(e);
    if (r) begin
      p_a = 0;
      known_a = 1'b1;
    end else if (pe) begin
      p_a = (p_a + 1) % FT_A;
    end
  endtask

  task automatic step_b(input bit r, input bit pe);
    exp_t e;
    @(posedge clk);
    #1;
    rst_b       = r;
    if_b.pix_en = pe;
    e = predict(1, p_b, r, pe);
    e.known = known_b;
    q_b.push_back(e);
    if (r) begin
      p_b = 0;
      known_b = 1'b1;
    end else if (pe) begin
      p_b = (p_b + 1) % FT_B;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic run_a();
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b1);
    step_a(1'b0, 1'b1);
    repeat (10) step_a(1'b0, 1'b0);
    // Past the line wrap and the hsync window, stopping at x=300 of line 1.
    while (p_a != 800 + 300) step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    repeat (2500) step_a(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic run_b();
    step_b(1'b1, 1'b0);
    step_b(1'b1, 1'b1);
    repeat (700) step_b(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0));
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        if (e.known) begin
          chk("A.xcounter",    32'(if_a.xcounter),   e.x);
          chk("A.ycounter",    32'(if_a.ycounter),   e.y);
          chk("A.hsync",       32'(if_a.hsync),      int'(e.hs));
          chk("A.vsync",       32'(if_a.vsync),      int'(e.vs));
          chk("A.video_on",    32'(if_a.video_on),   int'(e.von));
          chk("A.frame_start", 32'(if_a.frame_start), int'(e.fs));
          chk("A.line_end",    32'(if_a.line_end),   int'(e.le));
          chk("A.max_x",       32'(if_a.max_x),      e.mx);
          chk("A.max_y",       32'(if_a.max_y),      e.my);
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        if (e.known) begin
          chk("B.xcounter",    32'(if_b.xcounter),   e.x);
          chk("B.ycounter",    32'(if_b.ycounter),   e.y);
          chk("B.hsync",       32'(if_b.hsync),      int'(e.hs));
          chk("B.vsync",       32'(if_b.vsync),      int'(e.vs));
          chk("B.video_on",    32'(if_b.video_on),   int'(e.von));
          chk("B.frame_start", 32'(if_b.frame_start), int'(e.fs));
          chk("B.line_end",    32'(if_b.line_end),   int'(e.le));
          chk("B.max_x",       32'(if_b.max_x),      e.mx);
          chk("B.max_y",       32'(if_b.max_y),      e.my);
          if (if_b.frame_start === 1'b1) fs_cnt_b++;
        end
      end
    end
  end

  initial begin : main
    int exp_fs_b;
    exp_fs_b = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.pix_en = 1'b0;
    if_b.pix_en = 1'b0;
    fork
      run_a();
      begin
        run_b();
        exp_fs_b = 1;
      end
    join
    repeat (3) @(posedge clk);
    chk("queue_drain", 32'(q_a.size() + q_b.size()), 0);
    // Random small-config run spans many 48-tick frames, so frame_start must have fired.
    if (exp_fs_b == 1) chk("B.frame_seen", 32'(fs_cnt_b > 3), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
